// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port integer register file for the K_DSP core. It sits
// between decode/issue, which reads operands and issues destinations, and
// writeback, which writes results.
//
// Features:
//   - NREAD independent synchronous read ports (1-cycle latency).
//   - One write port. Register 0 is hardwired to zero.
//   - A per-register busy scoreboard for RAW hazard detection. Issue sets a
//     bit and writeback clears it. When both hit the same index on one edge,
//     the set wins, because a newer producer is still outstanding.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   - Defined   : write-first. A read that collides with a same-edge write
//                 returns wr_data and the post-update busy bit.
//   - Undefined : read-first. A colliding read returns the pre-write value
//                 and the pre-update busy bit.
//
// Parameters:
//   XLEN  - data width in bits
//   NREGS - number of registers (power of two, >= 2)
//   NREAD - number of read ports (1..4)
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high
//   rs_en       in   [NREAD]        per-port read enable
//   rs_index    in   [NREAD*AW]     port p index at [p*AW +: AW]
//   rs_data     out  [NREAD*XLEN]   registered read data, port p at [p*XLEN +: XLEN]
//   rs_valid    out  [NREAD]        read data valid, one cycle after rs_en
//   rs_busy     out  [NREAD]        scoreboard bit of the sampled index
//   wr_en       in                  write enable
//   wr_index    in   [AW]           write index
//   wr_data     in   [XLEN]         write data
//   issue_en    in                  mark issue_index as having an outstanding write
//   issue_index in   [AW]           destination register being issued
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD-1:0]      rs_en,
    input  logic [NREAD*AW-1:0]   rs_index,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_valid,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_index,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_index
);

    // Storage and scoreboard state
    logic [XLEN-1:0]       r_regs [NREGS];
    logic [NREGS-1:0]      r_busy;

    // Registered read-port outputs
    logic [NREAD*XLEN-1:0] r_rs_data;
    logic [NREAD-1:0]      r_rs_valid;
    logic [NREAD-1:0]      r_rs_busy;

    // Qualified write and issue strobes. Index 0 never takes effect.
    logic                  w_wr_hit;
    logic                  w_issue_hit;
    logic [NREGS-1:0]      w_busy_next;

    // Per-port combinational read results. They are captured on the edge.
    logic [XLEN-1:0]       w_rd_data [NREAD];
    logic [NREAD-1:0]      w_rd_busy;

    assign w_wr_hit    = wr_en    && (wr_index    != '0);
    assign w_issue_hit = issue_en && (issue_index != '0);

    // Next scoreboard state. The clear is applied before the set, so a
    // same-index issue overrides the writeback.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first;
        // a path that leaves it unassigned would infer a latch.
        w_busy_next = r_busy;
        if (w_wr_hit) begin
            w_busy_next[wr_index] = 1'b0;
        end
        if (w_issue_hit) begin
            w_busy_next[issue_index] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Read mux for each port. It applies the collision rule and the r0 override.
    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            w_rd_data[p] = r_regs[rs_index[p*AW +: AW]];
            w_rd_busy[p] = r_busy[rs_index[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // Write-first: forward the value being written this edge and
            // report the busy bit as it will be after this edge.
            if (w_wr_hit && (rs_index[p*AW +: AW] == wr_index)) begin
                w_rd_data[p] = wr_data;
                w_rd_busy[p] = w_busy_next[wr_index];
            end
`endif
            if (rs_index[p*AW +: AW] == '0) begin
                w_rd_data[p] = '0;
                w_rd_busy[p] = 1'b0;
            end
        end
    end

    // Register array and scoreboard
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the array is deliberately reset. The architecture requires
            // all registers to read 0 after reset, so this cannot be a plain RAM.
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_hit) begin
                r_regs[wr_index] <= wr_data;
            end
            r_busy <= w_busy_next;
        end
    end

    // Read ports. An idle port drops valid and holds its data and busy bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs_data  <= '0;
            r_rs_valid <= '0;
            r_rs_busy  <= '0;
        end else begin
            for (int p = 0; p < NREAD; p++) begin
                r_rs_valid[p] <= rs_en[p];
                if (rs_en[p]) begin
                    r_rs_data[p*XLEN +: XLEN] <= w_rd_data[p];
                    r_rs_busy[p]              <= w_rd_busy[p];
                end
            end
        end
    end

    assign rs_data  = r_rs_data;
    assign rs_valid = r_rs_valid;
    assign rs_busy  = r_rs_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Directed testbench for regfile_mp with three read ports.
// Inputs are driven on the falling edge. Outputs are checked on the next
// falling edge, after the rising edge that sampled the inputs.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 3;
    localparam int AW    = 5;

    logic                  clk;
    logic                  reset;
    logic [NREAD-1:0]      rs_en;
    logic [NREAD*AW-1:0]   rs_index;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_valid;
    logic [NREAD-1:0]      rs_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_index;
    logic [XLEN-1:0]       wr_data;
    logic                  issue_en;
    logic [AW-1:0]         issue_index;

    int checks;
    int errors;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_en       (rs_en),
        .rs_index    (rs_index),
        .rs_data     (rs_data),
        .rs_valid    (rs_valid),
        .rs_busy     (rs_busy),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_index (issue_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge. One rising edge passes in between.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] idx, input logic [XLEN-1:0] d);
        wr_en = 1'b1; wr_index = idx; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_issue(input logic [AW-1:0] idx);
        issue_en = 1'b1; issue_index = idx;
        tick();
        issue_en = 1'b0;
    endtask

    // Single read on port p. The outputs are visible when this returns.
    task automatic do_read(input int p, input logic [AW-1:0] idx);
        rs_en = '0;
        rs_en[p] = 1'b1;
        rs_index[p*AW +: AW] = idx;
        tick();
        rs_en = '0;
    endtask

    task automatic test_reset();
        // Power-on reset
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (rs_data !== '0 || rs_valid !== '0 || rs_busy !== '0) begin
            errors++;
            $display("FAIL reset_outputs data=%h valid=%b busy=%b expected all 0", rs_data, rs_valid, rs_busy);
        end
        // Preload r5 and mark it busy, then reset and read it back
        do_write(5'd5, 32'hDEADBEEF);
        do_issue(5'd5);
        do_read(0, 5'd5);
        checks++;
        if (rs_data[31:0] !== 32'hDEADBEEF || rs_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload data=%h busy=%b expected deadbeef/1", rs_data[31:0], rs_busy[0]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_read(0, 5'd5);
        checks++;
        if (rs_data[31:0] !== 32'h0 || rs_valid[0] !== 1'b1 || rs_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_r5 data=%h valid=%b busy=%b expected 0/1/0", rs_data[31:0], rs_valid[0], rs_busy[0]);
        end
    endtask

    task automatic test_reg0();
        do_write(5'd0, 32'h12345678);
        rs_en = 3'b111; rs_index = '0;
        tick();
        rs_en = '0;
        checks++;
        if (rs_data !== '0 || rs_valid !== 3'b111 || rs_busy !== 3'b000) begin
            errors++;
            $display("FAIL reg0_read data=%h valid=%b busy=%b expected 0/111/000", rs_data, rs_valid, rs_busy);
        end
        do_issue(5'd0);
        rs_en = 3'b111; rs_index = '0;
        tick();
        rs_en = '0;
        checks++;
        if (rs_busy !== 3'b000 || rs_data !== '0) begin
            errors++;
            $display("FAIL reg0_busy busy=%b data=%h expected 000/0", rs_busy, rs_data);
        end
    endtask

    task automatic test_multiport();
        do_write(5'd1, 32'h11);
        do_write(5'd4, 32'h44);
        do_write(5'd31, 32'hFFFFFFFF);
        rs_en = 3'b111;
        rs_index = {5'd31, 5'd4, 5'd1};
        tick();
        rs_en = '0;
        checks++;
        if (rs_data !== {32'hFFFFFFFF, 32'h44, 32'h11} || rs_valid !== 3'b111) begin
            errors++;
            $display("FAIL multiport_read data=%h valid=%b expected ffffffff_00000044_00000011/111", rs_data, rs_valid);
        end
        // The ports are idle: valid drops and the data holds
        tick();
        checks++;
        if (rs_valid !== 3'b000 || rs_data !== {32'hFFFFFFFF, 32'h44, 32'h11}) begin
            errors++;
            $display("FAIL multiport_idle valid=%b data=%h expected 000/held", rs_valid, rs_data);
        end
        // All ports read the same index
        rs_en = 3'b111;
        rs_index = {5'd4, 5'd4, 5'd4};
        tick();
        rs_en = '0;
        checks++;
        if (rs_data !== {32'h44, 32'h44, 32'h44}) begin
            errors++;
            $display("FAIL multiport_same data=%h expected 44 on all ports", rs_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]   idx [3];
        logic [XLEN-1:0] exp [3];
        idx[0] = 5'd1;  exp[0] = 32'h11;
        idx[1] = 5'd31; exp[1] = 32'hFFFFFFFF;
        idx[2] = 5'd4;  exp[2] = 32'h44;
        rs_en = 3'b100;
        for (int i = 0; i < 3; i++) begin
            rs_index[2*AW +: AW] = idx[i];
            tick();
            checks++;
            if (rs_data[2*XLEN +: XLEN] !== exp[i] || rs_valid[2] !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d] data=%h valid=%b expected %h/1", i, rs_data[2*XLEN +: XLEN], rs_valid[2], exp[i]);
            end
        end
        rs_en = '0;
    endtask

    task automatic test_collision();
        logic [XLEN-1:0] exp_d;
        logic            exp_b;
        do_write(5'd7, 32'hA);
        // Same edge: write r7=B and read r7 on port 0
        wr_en = 1'b1; wr_index = 5'd7; wr_data = 32'hB;
        rs_en = 3'b001; rs_index[0 +: AW] = 5'd7;
        tick();
        wr_en = 1'b0; rs_en = '0;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'hB;
`else
        exp_d = 32'hA;
`endif
        checks++;
        if (rs_data[31:0] !== exp_d) begin
            errors++;
            $display("FAIL collision_data data=%h expected %h", rs_data[31:0], exp_d);
        end
        do_read(0, 5'd7);
        checks++;
        if (rs_data[31:0] !== 32'hB) begin
            errors++;
            $display("FAIL collision_after data=%h expected 0000000b", rs_data[31:0]);
        end
        // Busy collision: r8 busy, then write r8 and read r8 on the same edge
        do_issue(5'd8);
        wr_en = 1'b1; wr_index = 5'd8; wr_data = 32'h88;
        rs_en = 3'b010; rs_index[AW +: AW] = 5'd8;
        tick();
        wr_en = 1'b0; rs_en = '0;
`ifdef REGFILE_BYPASS_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        checks++;
        if (rs_busy[1] !== exp_b) begin
            errors++;
            $display("FAIL collision_busy busy=%b expected %b", rs_busy[1], exp_b);
        end
    endtask

    task automatic test_scoreboard();
        do_issue(5'd9);
        do_read(0, 5'd9);
        checks++;
        if (rs_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue busy=%b expected 1", rs_busy[0]);
        end
        do_write(5'd9, 32'h99);
        do_read(0, 5'd9);
        checks++;
        if (rs_busy[0] !== 1'b0 || rs_data[31:0] !== 32'h99) begin
            errors++;
            $display("FAIL sb_write busy=%b data=%h expected 0/00000099", rs_busy[0], rs_data[31:0]);
        end
        // Issue and write to the same index on one edge: set wins
        issue_en = 1'b1; issue_index = 5'd9;
        wr_en = 1'b1; wr_index = 5'd9; wr_data = 32'h100;
        tick();
        issue_en = 1'b0; wr_en = 1'b0;
        do_read(0, 5'd9);
        checks++;
        if (rs_busy[0] !== 1'b1 || rs_data[31:0] !== 32'h100) begin
            errors++;
            $display("FAIL sb_same_edge busy=%b data=%h expected 1/00000100", rs_busy[0], rs_data[31:0]);
        end
        // Issue r10 and write r9 on one edge: both take effect
        issue_en = 1'b1; issue_index = 5'd10;
        wr_en = 1'b1; wr_index = 5'd9; wr_data = 32'h5;
        tick();
        issue_en = 1'b0; wr_en = 1'b0;
        rs_en = 3'b011;
        rs_index[0 +: AW] = 5'd9;
        rs_index[AW +: AW] = 5'd10;
        tick();
        rs_en = '0;
        checks++;
        if (rs_busy[1:0] !== 2'b10 || rs_data[31:0] !== 32'h5) begin
            errors++;
            $display("FAIL sb_diff_index busy=%b data=%h expected 10/00000005", rs_busy[1:0], rs_data[31:0]);
        end
    endtask

    task automatic test_midstream_reset();
        do_write(5'd3, 32'h33);
        rs_en = 3'b010;
        rs_index[AW +: AW] = 5'd3;
        tick();
        checks++;
        if (rs_valid[1] !== 1'b1 || rs_data[XLEN +: XLEN] !== 32'h33) begin
            errors++;
            $display("FAIL mid_before valid=%b data=%h expected 1/00000033", rs_valid[1], rs_data[XLEN +: XLEN]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (rs_valid[1] !== 1'b0 || rs_data[XLEN +: XLEN] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset valid=%b data=%h expected 0/0", rs_valid[1], rs_data[XLEN +: XLEN]);
        end
        tick();
        checks++;
        if (rs_valid[1] !== 1'b1 || rs_data[XLEN +: XLEN] !== 32'h0) begin
            errors++;
            $display("FAIL mid_after valid=%b data=%h expected 1/0", rs_valid[1], rs_data[XLEN +: XLEN]);
        end
        rs_en = '0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        rs_en       = '0;
        rs_index    = '0;
        wr_en       = 1'b0;
        wr_index    = '0;
        wr_data     = '0;
        issue_en    = 1'b0;
        issue_index = '0;
        tick();

        test_reset();
        test_reg0();
        test_multiport();
        test_back_to_back();
        test_collision();
        test_scoreboard();
        test_midstream_reset();

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
